// File: rtl/weights_bpr_seq.sv
// Sequential weight/BPR/ETC walker: emits one registered beat per active tap over valid/ready.
// Optional macro WBPR_ZERO_SKIP_EN drops taps whose ETC is zero.
module weights_bpr_seq #(
  parameter int NB_WEIGHTS = 5,
  parameter int DATA_WIDTH = 16,
  parameter int BPR_WIDTH  = ((DATA_WIDTH+1)/2)*3,
  parameter int ETC_WIDTH  = 4,
  parameter int TAP_WIDTH  = $clog2(NB_WEIGHTS+1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [TAP_WIDTH-1:0]             n_taps,
  input  logic [DATA_WIDTH*NB_WEIGHTS-1:0] WRegs,
  input  logic [BPR_WIDTH*NB_WEIGHTS-1:0]  WBPRs,
  input  logic [ETC_WIDTH*NB_WEIGHTS-1:0]  ETCs,
  input  logic                             out_ready,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            W,
  output logic [BPR_WIDTH-1:0]             BPR_W,
  output logic [ETC_WIDTH-1:0]             ETC_W,
  output logic [TAP_WIDTH-1:0]             tap_idx,
  output logic                             last,
  output logic                             busy,
  output logic                             done
);

  localparam logic [0:0]           S_IDLE = 1'b0;
  localparam logic [0:0]           S_RUN  = 1'b1;
  localparam logic [TAP_WIDTH-1:0] NB_T   = TAP_WIDTH'(NB_WEIGHTS);
  localparam logic [TAP_WIDTH-1:0] ONE_T  = TAP_WIDTH'(1);

  logic [NB_WEIGHTS-1:0][DATA_WIDTH-1:0] w_wregs;
  logic [NB_WEIGHTS-1:0][BPR_WIDTH-1:0]  w_wbprs;
  logic [NB_WEIGHTS-1:0][ETC_WIDTH-1:0]  w_etcs;
  assign w_wregs = WRegs;
  assign w_wbprs = WBPRs;
  assign w_etcs  = ETCs;

  logic [0:0]            r_state;
  logic [TAP_WIDTH-1:0]  r_n_eff;
  logic                  r_valid, r_last, r_busy, r_done;
  logic [DATA_WIDTH-1:0] r_w;
  logic [BPR_WIDTH-1:0]  r_bpr;
  logic [ETC_WIDTH-1:0]  r_etc;
  logic [TAP_WIDTH-1:0]  r_idx;

  logic [TAP_WIDTH-1:0]  w_n_eff, w_n, w_from, w_ld_idx;
  logic                  w_found, w_ld_last;
  logic [DATA_WIDTH-1:0] w_sel_w;
  logic [BPR_WIDTH-1:0]  w_sel_bpr;
  logic [ETC_WIDTH-1:0]  w_sel_etc;

  // Zero or oversize tap counts mean "use every slot".
  assign w_n_eff = (n_taps == '0 || n_taps > NB_T) ? NB_T : n_taps;
  assign w_n     = (r_state == S_IDLE) ? w_n_eff : r_n_eff;
  assign w_from  = (r_state == S_IDLE) ? '0 : r_idx + ONE_T;

`ifdef WBPR_ZERO_SKIP_EN
  // First non-zero slot at/after w_from is loaded; a second one means it is not last.
  always_comb begin
    logic w_more;
    w_found  = 1'b0;
    w_more   = 1'b0;
    w_ld_idx = '0;
    for (int i = 0; i < NB_WEIGHTS; i++) begin
      if (TAP_WIDTH'(i) >= w_from && TAP_WIDTH'(i) < w_n && w_etcs[i] != '0) begin
        if (!w_found) begin
          w_found  = 1'b1;
          w_ld_idx = TAP_WIDTH'(i);
        end else begin
          w_more = 1'b1;
        end
      end
    end
    w_ld_last = !w_more;
  end
`else
  always_comb begin
    w_found   = 1'b1;
    w_ld_idx  = w_from;
    w_ld_last = (w_from == w_n - ONE_T);
  end
`endif

  always_comb begin
    w_sel_w   = '0;
    w_sel_bpr = '0;
    w_sel_etc = '0;
    for (int i = 0; i < NB_WEIGHTS; i++) begin
      if (w_ld_idx == TAP_WIDTH'(i)) begin
        w_sel_w   = w_wregs[i];
        w_sel_bpr = w_wbprs[i];
        w_sel_etc = w_etcs[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_n_eff <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_w     <= '0;
      r_bpr   <= '0;
      r_etc   <= '0;
      r_idx   <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_n_eff <= w_n_eff;
          if (w_found) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_w     <= w_sel_w;
            r_bpr   <= w_sel_bpr;
            r_etc   <= w_sel_etc;
            r_idx   <= w_ld_idx;
            r_last  <= w_ld_last;
          end else begin
            r_done <= 1'b1;
          end
        end
      end else if (r_valid && out_ready) begin
        if (r_last) begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_w    <= w_sel_w;
          r_bpr  <= w_sel_bpr;
          r_etc  <= w_sel_etc;
          r_idx  <= w_ld_idx;
          r_last <= w_ld_last;
        end
      end
    end
  end

  assign out_valid = r_valid;
  assign W         = r_w;
  assign BPR_W     = r_bpr;
  assign ETC_W     = r_etc;
  assign tap_idx   = r_idx;
  assign last      = r_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: doc/weights_bpr_seq.md
Name: weights_bpr_seq

Overview:
Sequential successor to the per-PE weight/BPR/ETC selector. It walks the global WRegs/WBPRs/ETCs banks tap by tap and emits one registered {W, BPR_W, ETC_W, tap_idx} beat per tap over a valid/ready stream.
- Supports any NB_WEIGHTS, not only 5/7/11.
- Supports a runtime active-tap count.
- Sits between the global weight register bank and the FoFIR MAC datapath.

Parameters:
NB_WEIGHTS, 5, number of tap slots in the global banks (>=1)
DATA_WIDTH, 16, weight width
BPR_WIDTH, ((DATA_WIDTH+1)/2)*3, booth partial-recode width per weight
ETC_WIDTH, 4, effective-term-count width per weight
TAP_WIDTH, $clog2(NB_WEIGHTS+1), width of tap index and tap count

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle request to begin a sequence; honoured only in IDLE
n_taps  in  TAP_WIDTH  active tap count, sampled on accepted start
WRegs  in  DATA_WIDTH*NB_WEIGHTS  packed weights, tap i at [DATA_WIDTH*(i+1)-1:DATA_WIDTH*i]
WBPRs  in  BPR_WIDTH*NB_WEIGHTS  packed BPRs, same packing
ETCs  in  ETC_WIDTH*NB_WEIGHTS  packed ETCs, same packing
out_ready  in  1  downstream accepts beat
out_valid  out  1  beat valid
W  out  DATA_WIDTH  selected weight
BPR_W  out  BPR_WIDTH  selected BPR
ETC_W  out  ETC_WIDTH  selected ETC
tap_idx  out  TAP_WIDTH  tap index of current beat
last  out  1  current beat is final tap of sequence
busy  out  1  sequence in progress
done  out  1  one-cycle pulse after final beat accepted

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values: state=IDLE; out_valid, last, busy, done = 0; W, BPR_W, ETC_W, tap_idx = 0.
- States:
  - IDLE: start=1 -> RUN. Latch n_eff:
    - n_taps==0 or n_taps>NB_WEIGHTS -> NB_WEIGHTS.
    - Otherwise n_taps.
  - RUN: output register holds the current tap. On out_valid&&out_ready:
    - If last=0: load next tap. No bubble; next beat valid the following cycle.
    - If last=1: -> IDLE. out_valid=0, busy=0, done=1 for exactly one cycle.
- Latency: start at cycle t -> out_valid=1, tap_idx=0 at t+1. With out_ready held high, n_eff beats on consecutive cycles; done at t+n_eff+1.
- Data rule: W/BPR_W/ETC_W are taken from the live input banks at the cycle the tap is loaded into the output register.
  - Banks must be stable while busy=1; the block does not snapshot them.
  - Output fields are bit-exact slices, no arithmetic.
- Backpressure: while out_valid=1 and out_ready=0, all outputs hold stable (AXI-style). out_valid never drops without a handshake.
- last = (tap_idx == n_eff-1), registered together with the beat.
- busy = 1 from the cycle after an accepted start until the cycle done asserts.
- Boundary conditions:
  - start while busy: ignored.
  - n_taps sampled only on accepted start.
  - NB_WEIGHTS=1: single beat with last=1.
  - rst_n=0 mid-sequence: next edge returns to reset values, no done pulse.
  - start and rst_n=0 in the same cycle: reset wins.

Optional Feature:
Macro WBPR_ZERO_SKIP_EN.
- Defined: taps whose ETC==0 (zero weight) are never emitted.
  - The next tap loaded is the lowest index > current (or >=0 at start) with ETC!=0 and index < n_eff.
  - tap_idx reports the true slot index.
  - last marks the final non-zero tap.
  - If no non-zero tap exists: no beats; done pulses at t+1, busy stays 0.
- Undefined: every tap 0..n_eff-1 is emitted regardless of value; no skip logic is synthesised.

Test Plan:
- NB_WEIGHTS=5, W[i]=i+1, out_ready=1, start at cycle 10, n_taps=0 -> beats cycles 11..15, tap_idx 0..4, W 1..5, last only at cycle 15, done at cycle 16.
- Same setup, out_ready toggling 1,0,0,1,... -> each beat held stable while out_ready=0, exactly 5 handshakes in order, done one cycle after the 5th.
- NB_WEIGHTS=11, n_taps=3 -> tap_idx 0,1,2 with last on tap 2; n_taps=12 -> clamped to 11 beats.
- start pulsed again during RUN at tap 2 -> ignored, sequence completes normally with one done pulse.
- rst_n=0 for one cycle at tap 2 -> next cycle out_valid=0, busy=0, all outputs 0, no done pulse; a fresh start restarts at tap 0.
- WBPR_ZERO_SKIP_EN, NB_WEIGHTS=5, ETC[1]=ETC[3]=0 -> beats tap_idx 0,2,4, last on 4. With all ETC=0 -> no valid, done at t+1.
